// File: rtl/v_mul_pipe_pkg.sv
// Types shared by the SIMD multiplier: element-width and operation encodings.
package v_mul_pkg;
  typedef enum logic [1:0] {E8 = 2'b00, E16 = 2'b01, E32 = 2'b10, E64 = 2'b11} sew_t;
  typedef enum logic [1:0] {MUL = 2'b00, MULH = 2'b01, MULHU = 2'b10, MULHSU = 2'b11} mul_mode_t;

  function automatic int sew_bits(sew_t s);
    return 8 << s;
  endfunction
endpackage

// File: rtl/v_mul_pipe_if.sv
// Operand/result handshake bundle between the execute stage and the multiplier.
interface v_mul_pipe_if #(
  parameter int ELEN = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ELEN-1:0]      op_A;
  logic [ELEN-1:0]      op_B;
  v_mul_pkg::sew_t      sew;
  v_mul_pkg::mul_mode_t mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ELEN-1:0]      result;

  modport master (output in_valid, op_A, op_B, sew, mode, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op_A, op_B, sew, mode, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/v_mul_pipe_lane_ext.sv
// One SEW-wide multiply slice: extends both operands to SEW+1 bits per mode, then picks the low or high half.
module v_mul_lane_ext
  import v_mul_pkg::*;
#(
  parameter int SEW = 8
) (
  input  logic [SEW-1:0] a_i,
  input  logic [SEW-1:0] b_i,
  input  mul_mode_t      mode_i,
  output logic [SEW-1:0] res_o
);
  localparam int PW = 2*SEW + 2;

  logic          a_sgn, b_sgn;
  logic [SEW:0]  a_ext, b_ext;
  logic [PW-1:0] a_w, b_w, prod;

  assign a_sgn = (mode_i != MULHU);
  assign b_sgn = (mode_i == MUL) || (mode_i == MULH);
  assign a_ext = {a_sgn & a_i[SEW-1], a_i};
  assign b_ext = {b_sgn & b_i[SEW-1], b_i};
  // Low PW bits of a product of sign-extended operands equal the signed product.
  assign a_w   = {{(SEW+1){a_ext[SEW]}}, a_ext};
  assign b_w   = {{(SEW+1){b_ext[SEW]}}, b_ext};
  assign prod  = a_w * b_w;
  assign res_o = (mode_i == MUL) ? prod[SEW-1:0] : prod[2*SEW-1:SEW];
endmodule

// File: rtl/v_mul_pipe.sv
// Pipelined SIMD multiplier: per-SEW lane banks feed an elastic STAGES-deep valid/ready pipe.
module v_mul_pipe
  import v_mul_pkg::*;
#(
  parameter int ELEN   = 32,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         flush,
  v_mul_pipe_if.slave  bus
);
  logic [ELEN-1:0] r8, r16, r32, r64, res_d;

  for (genvar i = 0; i < ELEN/8; i++) begin : g_e8
    v_mul_lane_ext #(.SEW(8)) u_lane (
      .a_i(bus.op_A[i*8 +: 8]), .b_i(bus.op_B[i*8 +: 8]), .mode_i(bus.mode), .res_o(r8[i*8 +: 8]));
  end
  for (genvar i = 0; i < ELEN/16; i++) begin : g_e16
    v_mul_lane_ext #(.SEW(16)) u_lane (
      .a_i(bus.op_A[i*16 +: 16]), .b_i(bus.op_B[i*16 +: 16]), .mode_i(bus.mode), .res_o(r16[i*16 +: 16]));
  end
  for (genvar i = 0; i < ELEN/32; i++) begin : g_e32
    v_mul_lane_ext #(.SEW(32)) u_lane (
      .a_i(bus.op_A[i*32 +: 32]), .b_i(bus.op_B[i*32 +: 32]), .mode_i(bus.mode), .res_o(r32[i*32 +: 32]));
  end
  if (ELEN == 64) begin : g_e64
    v_mul_lane_ext #(.SEW(64)) u_lane (
      .a_i(bus.op_A), .b_i(bus.op_B), .mode_i(bus.mode), .res_o(r64));
  end else begin : g_no_e64
    assign r64 = '0;
  end

  // Element widths wider than the datapath flow through as zero.
  always_comb begin
    res_d = '0;
    if (sew_bits(bus.sew) <= ELEN) begin
      case (bus.sew)
        E8:  res_d = r8;
        E16: res_d = r16;
        E32: res_d = r32;
        E64: res_d = r64;
        default: res_d = '0;
      endcase
    end
  end

  logic            vld_q [STAGES];
  logic            vld_d [STAGES];
  logic [ELEN-1:0] dat_q [STAGES];
  logic            adv   [STAGES];
  logic            in_fire;

  assign bus.in_ready = !flush && adv[0];
  assign in_fire      = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic            vld_in;
    logic [ELEN-1:0] dat_in;

    if (k == STAGES-1) begin : g_last
      assign adv[k] = !vld_q[k] || bus.out_ready;
    end else begin : g_mid
      assign adv[k] = !vld_q[k] || adv[k+1];
    end

    if (k == 0) begin : g_first
      assign vld_in = in_fire;
      assign dat_in = res_d;
    end else begin : g_next
      assign vld_in = vld_q[k-1];
      assign dat_in = dat_q[k-1];
    end

    assign vld_d[k] = flush ? 1'b0 : (adv[k] ? vld_in : vld_q[k]);

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) vld_q[k] <= 1'b0;
      else       vld_q[k] <= vld_d[k];
    end

    always_ff @(posedge clk) begin
      if (adv[k] && vld_in) dat_q[k] <= dat_in;
    end
  end

  // Gating by valid gives result=0 in reset without resetting the data regs.
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = vld_q[STAGES-1] ? dat_q[STAGES-1] : '0;
endmodule

// File: tb/tb_v_mul_pipe.sv
// Directed bench: ELEN=32 and ELEN=64 instances share one stimulus stream.
module tb_v_mul_pipe;
  import v_mul_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  sew_t        sew = E8;
  mul_mode_t   mode = MUL;
  int          vecs = 0;
  int          errs = 0;

  typedef struct { logic [31:0] a, b; sew_t s; mul_mode_t m; logic [31:0] e; } v32_t;
  typedef struct { logic [63:0] a, b; sew_t s; mul_mode_t m; logic [63:0] e; } v64_t;

  v_mul_pipe_if #(.ELEN(32)) b32 ();
  v_mul_pipe_if #(.ELEN(64)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.out_ready = out_ready;
  assign b32.op_A      = a[31:0];
  assign b32.op_B      = b[31:0];
  assign b32.sew       = sew;
  assign b32.mode      = mode;
  assign b64.in_valid  = in_valid;
  assign b64.out_ready = out_ready;
  assign b64.op_A      = a;
  assign b64.op_B      = b;
  assign b64.sew       = sew;
  assign b64.mode      = mode;

  v_mul_pipe #(.ELEN(32), .STAGES(3)) dut32 (.clk(clk), .nrst(nrst), .flush(flush), .bus(b32));
  v_mul_pipe #(.ELEN(64), .STAGES(3)) dut64 (.clk(clk), .nrst(nrst), .flush(flush), .bus(b64));

  always #5 clk = ~clk;

  task automatic do_op(input logic [63:0] oa, input logic [63:0] ob, input sew_t s,
                       input mul_mode_t m, output logic [31:0] r32, output logic [63:0] r64,
                       output bit ok);
    @(negedge clk);
    a = oa; b = ob; sew = s; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1'b0; r32 = '0; r64 = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (b32.out_valid) begin ok = 1'b1; r32 = b32.result; r64 = b64.result; end
    end
    @(posedge clk);
  endtask

  task automatic fill3(output int n);
    n = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sew = E32; mode = MUL;
    for (int i = 0; i < 3; i++) begin
      a = 64'(i + 2); b = 64'd3;
      #1 if (b32.in_ready) n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    @(negedge clk);
    vecs++;
    if (b32.out_valid !== 1'b0 || b32.result !== 32'h0) begin
      errs++; $display("FAIL reset_hold: out_valid=%b result=%h, required 0/00000000", b32.out_valid, b32.result);
    end
    nrst = 1'b1;
    @(negedge clk);
    vecs++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", b32.in_ready, b32.out_valid);
    end
  endtask

  task automatic test_modes32();
    v32_t        tv[11];
    logic [31:0] r32;
    logic [63:0] r64;
    bit          ok;
    tv[0]  = '{32'h05FF7F80, 32'h03020202, E8,  MUL,    32'h0FFEFE00};
    tv[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, E16, MULH,   32'h00000000};
    tv[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, E16, MULHU,  32'hFFFEFFFE};
    tv[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, E16, MULHSU, 32'hFFFFFFFF};
    tv[4]  = '{32'h00010000, 32'h00010000, E32, MUL,    32'h00000000};
    tv[5]  = '{32'h00010000, 32'h00010000, E32, MULH,   32'h00000001};
    tv[6]  = '{32'h12345678, 32'h00000010, E32, MUL,    32'h23456780};
    tv[7]  = '{32'hFFFFFFFF, 32'h02020202, E8,  MULHU,  32'h01010101};
    tv[8]  = '{32'h80808080, 32'hFFFFFFFF, E8,  MULHSU, 32'h80808080};
    tv[9]  = '{32'h80808080, 32'h80808080, E8,  MULH,   32'h40404040};
    tv[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, E64, MULHU,  32'h00000000};
    for (int i = 0; i < 11; i++) begin
      do_op({32'h0, tv[i].a}, {32'h0, tv[i].b}, tv[i].s, tv[i].m, r32, r64, ok);
      vecs++;
      if (!ok) begin
        errs++; $display("FAIL modes32[%0d]: out_valid never rose, required 1", i);
      end else if (r32 !== tv[i].e) begin
        errs++; $display("FAIL modes32[%0d]: result=%h, required %h", i, r32, tv[i].e);
      end
    end
  endtask

  task automatic test_elen64();
    v64_t        tv[5];
    logic [31:0] r32;
    logic [63:0] r64;
    bit          ok;
    tv[0] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, E64, MULHU,  64'hFFFFFFFFFFFFFFFE};
    tv[1] = '{64'h0102030405060708, 64'h0202020202020202, E8,  MUL,    64'h020406080A0C0E10};
    tv[2] = '{64'h0001000000010000, 64'h0001000000010000, E32, MULH,   64'h0000000100000001};
    tv[3] = '{64'h8000000000000000, 64'h0000000000000002, E64, MULH,   64'hFFFFFFFFFFFFFFFF};
    tv[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, E64, MULHSU, 64'hFFFFFFFFFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      do_op(tv[i].a, tv[i].b, tv[i].s, tv[i].m, r32, r64, ok);
      vecs++;
      if (!ok) begin
        errs++; $display("FAIL elen64[%0d]: out_valid never rose, required 1", i);
      end else if (r64 !== tv[i].e) begin
        errs++; $display("FAIL elen64[%0d]: result=%h, required %h", i, r64, tv[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[8];
    int          sent = 0, recv = 0, acc_it = -1, ov_it = -1, hits = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    for (int i = 0; i < 8; i++)
      exp_q[i] = (i % 2 == 0) ? (32'(i + 1) << 8) : (32'h01010101 * 32'(2 * i));
    for (int it = 0; it < 200 && recv < 8; it++) begin
      @(negedge clk);
      if (prev_stall) begin
        vecs++;
        if (b32.out_valid !== 1'b1 || b32.result !== prev_res) begin
          errs++; $display("FAIL b2b_hold: out_valid=%b result=%h, required 1/%h", b32.out_valid, b32.result, prev_res);
        end
      end
      if (b32.out_valid && ov_it < 0) ov_it = it;
      if (sent < 8) begin
        in_valid = 1'b1;
        if (sent % 2 == 0) begin a = 64'(sent + 1); b = 64'h100; sew = E32; mode = MUL; end
        else begin a = 64'h01010101 * 64'(sent); b = 64'h02020202; sew = E8; mode = MUL; end
      end else in_valid = 1'b0;
      out_ready = (it < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_valid && b32.in_ready) begin
        if (acc_it < 0) acc_it = it;
        sent++;
      end
      if (b32.out_valid && out_ready) begin
        vecs++;
        if (b32.result !== exp_q[recv]) begin
          errs++; $display("FAIL b2b_data[%0d]: result=%h, required %h", recv, b32.result, exp_q[recv]);
        end
        recv++;
      end
      prev_stall = b32.out_valid && !out_ready;
      prev_res   = b32.result;
    end
    in_valid = 1'b0;
    vecs++;
    if (ov_it - acc_it != 3) begin
      errs++; $display("FAIL b2b_latency: first out_valid %0d cycles after accept, required 3", ov_it - acc_it);
    end
    vecs++;
    if (sent != 8 || recv != 8) begin
      errs++; $display("FAIL b2b_count: sent=%0d recv=%0d, required 8/8", sent, recv);
    end
    out_ready = 1'b1;
    repeat (5) begin @(negedge clk); if (b32.out_valid) hits++; end
    vecs++;
    if (hits != 0) begin
      errs++; $display("FAIL b2b_dup: %0d extra results, required 0", hits);
    end
  endtask

  task automatic test_flush();
    int n, hits = 0;
    fill3(n);
    vecs++;
    if (n != 3) begin errs++; $display("FAIL flush_fill: accepted %0d, required 3", n); end
    vecs++;
    if (b32.out_valid !== 1'b1 || b32.result !== 32'd6) begin
      errs++; $display("FAIL flush_full: out_valid=%b result=%h, required 1/00000006", b32.out_valid, b32.result);
    end
    in_valid = 1'b1; a = 64'd7; b = 64'd7;
    #1 vecs++;
    if (b32.in_ready !== 1'b0) begin errs++; $display("FAIL full_ready: in_ready=%b, required 0", b32.in_ready); end
    flush = 1'b1;
    #1 vecs++;
    if (b32.in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready: in_ready=%b, required 0", b32.in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    vecs++;
    if (b32.out_valid !== 1'b0 || b32.result !== 32'h0) begin
      errs++; $display("FAIL flush_clear: out_valid=%b result=%h, required 0/00000000", b32.out_valid, b32.result);
    end
    #1 vecs++;
    if (b32.in_ready !== 1'b1) begin errs++; $display("FAIL flush_after: in_ready=%b, required 1", b32.in_ready); end
    // One op in flight, and an offered op during flush must also be dropped.
    in_valid = 1'b1; a = 64'd5; b = 64'd5; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1 vecs++;
    if (b32.in_ready !== 1'b0) begin errs++; $display("FAIL flush_partial_ready: in_ready=%b, required 0", b32.in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (6) begin if (b32.out_valid) hits++; @(negedge clk); end
    vecs++;
    if (hits != 0) begin errs++; $display("FAIL flush_stale: %0d results after flush, required 0", hits); end
  endtask

  task automatic test_reset_mid();
    int n, hits = 0;
    fill3(n);
    vecs++;
    if (n != 3 || b32.out_valid !== 1'b1) begin
      errs++; $display("FAIL rst_fill: accepted %0d out_valid=%b, required 3/1", n, b32.out_valid);
    end
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 vecs++;
    if (b32.out_valid !== 1'b0 || b32.result !== 32'h0) begin
      errs++; $display("FAIL rst_async: out_valid=%b result=%h, required 0/00000000", b32.out_valid, b32.result);
    end
    @(negedge clk);
    nrst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (b32.in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: in_ready=%b, required 1", b32.in_ready); end
    repeat (6) begin if (b32.out_valid) hits++; @(negedge clk); end
    vecs++;
    if (hits != 0) begin errs++; $display("FAIL rst_stale: %0d results after reset, required 0", hits); end
  endtask

  initial begin
    test_reset();
    test_modes32();
    test_elen64();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
